// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one pipelined memory port between fetch and data.
// Data wins by default; a starvation counter forces a fetch grant.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_abort,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_abort,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        abort,
  output logic        write,
  output logic        size,
  output logic [1:0]  prot,
  output logic [1:0]  trans
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starved;
  logic [1:0]  addr_owner;
  logic [1:0]  resp_owner;
  logic [1:0]  next_owner;
  logic [31:0] nxt_addr;
  logic        nxt_write;
  logic [1:0]  nxt_prot;
  logic        seq;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  assign starved = i_req && (starve_cnt == LIMIT);
  assign d_gnt   = n_reset && d_req && !starved;
  assign i_gnt   = n_reset && i_req && !d_gnt;

  always_comb begin
    next_owner = OWN_NONE;
    unique case (1'b1)
      d_gnt:   next_owner = OWN_DATA;
      i_gnt:   next_owner = OWN_FETCH;
      default: next_owner = OWN_NONE;
    endcase
  end

  assign nxt_addr  = d_gnt ? d_addr : i_addr;
  assign nxt_write = d_gnt & d_write;
  assign nxt_prot  = d_gnt ? 2'b01 : 2'b00;

  // Sequential only when continuing the previous cycle's live burst.
  assign seq = (trans != 2'b00)
            && (prot == nxt_prot)
            && (write == nxt_write)
            && (nxt_addr == addr + 32'd1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr  <= '0;
      wdata <= '0;
      write <= 1'b0;
      size  <= 1'b0;
      prot  <= 2'b00;
      trans <= 2'b00;
    end else if (next_owner != OWN_NONE) begin
      addr  <= nxt_addr;
      write <= nxt_write;
      size  <= d_gnt ? d_size : 1'b1;
      prot  <= nxt_prot;
      trans <= seq ? 2'b11 : 2'b10;
      if (d_gnt) wdata <= d_wdata;
    end else begin
      trans <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr_owner <= OWN_NONE;
      resp_owner <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      addr_owner <= next_owner;
      resp_owner <= addr_owner;
      if (!i_req || i_gnt)
        starve_cnt <= '0;
      else if (d_gnt && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign i_rvalid = (resp_owner == OWN_FETCH);
  assign d_rvalid = (resp_owner == OWN_DATA);
  assign i_abort  = i_rvalid & abort;
  assign d_abort  = d_rvalid & abort;
  assign i_rdata  = i_rvalid ? rdata : i_rdata_q;
  assign d_rdata  = d_rvalid ? rdata : d_rdata_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rvalid) i_rdata_q <= rdata;
      if (d_rvalid) d_rdata_q <= rdata;
    end
  end

endmodule
